// File: rtl/icg_enable_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : icg_enable_ctrl
//  Purpose  : Enable/test-enable generator for a negative-edge ICG, with idle
//             hysteresis, wake-latency READY flag and gated-cycle statistics.
//  Revision : 1.0 - initial release
// ============================================================================
module icg_enable_ctrl #(
    parameter int IDLE_CYCLES = 16,
    parameter int WAKE_LAT    = 2,
    parameter int CNT_W       = 16
) (
    input  logic             CLK,
    input  logic             RN,
    input  logic             BUSY,
    input  logic             FORCE_ON,
    input  logic             SE,
    input  logic             CLR,
    output logic             E,
    output logic             TE,
    output logic             READY,
    output logic             GATED,
    output logic [CNT_W-1:0] GCNT
);

    typedef enum logic [1:0] {
        ST_GATED = 2'd0,
        ST_WAKE  = 2'd1,
        ST_RUN   = 2'd2,
        ST_DRAIN = 2'd3
    } state_t;

    localparam logic [7:0]       c_wake_init = 8'(WAKE_LAT - 1);
    localparam logic [7:0]       c_idle_init = 8'(IDLE_CYCLES - 1);
    localparam logic [CNT_W-1:0] c_gcnt_max  = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] c_gcnt_one  = CNT_W'(1);

    state_t           r_state;
    state_t           w_state_nxt;
    logic [7:0]       r_cnt;
    logic [7:0]       w_cnt_nxt;
    logic             w_act;
    logic             r_e;
    logic             r_ready;
    logic             r_gated;
    logic [CNT_W-1:0] r_gcnt;

    assign w_act = BUSY | FORCE_ON;

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        case (r_state)
            ST_GATED: begin
                if (w_act) begin
                    if (WAKE_LAT > 0) begin
                        w_state_nxt = ST_WAKE;
                        w_cnt_nxt   = c_wake_init;
                    end else begin
                        w_state_nxt = ST_RUN;
                    end
                end
            end
            // Activity is deliberately ignored here so a wake always completes.
            ST_WAKE: begin
                if (r_cnt == 8'd0) begin
                    w_state_nxt = ST_RUN;
                end else begin
                    w_cnt_nxt = r_cnt - 8'd1;
                end
            end
            ST_RUN: begin
                if (!w_act) begin
                    w_state_nxt = ST_DRAIN;
                    w_cnt_nxt   = c_idle_init;
                end
            end
            ST_DRAIN: begin
                // Clock never stopped while draining, so resume without wake latency.
                if (w_act) begin
                    w_state_nxt = ST_RUN;
                end else if (r_cnt == 8'd0) begin
                    w_state_nxt = ST_GATED;
                end else begin
                    w_cnt_nxt = r_cnt - 8'd1;
                end
            end
            default: begin
                w_state_nxt = ST_GATED;
                w_cnt_nxt   = 8'd0;
            end
        endcase
    end

    // Outputs are flopped from the next-state decode so E only moves on CLK rise.
    always_ff @(posedge CLK or negedge RN) begin
        if (!RN) begin
            r_state <= ST_GATED;
            r_cnt   <= 8'd0;
            r_e     <= 1'b0;
            r_ready <= 1'b0;
            r_gated <= 1'b1;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_e     <= (w_state_nxt != ST_GATED);
            r_ready <= (w_state_nxt == ST_RUN) || (w_state_nxt == ST_DRAIN);
            r_gated <= (w_state_nxt == ST_GATED);
        end
    end

    always_ff @(posedge CLK or negedge RN) begin
        if (!RN) begin
            r_gcnt <= '0;
        end else if (CLR) begin
            r_gcnt <= '0;
        end else if ((r_state == ST_GATED) && (r_gcnt != c_gcnt_max)) begin
            r_gcnt <= r_gcnt + c_gcnt_one;
        end
    end

    assign E     = r_e;
    assign TE    = SE;
    assign READY = r_ready;
    assign GATED = r_gated;
    assign GCNT  = r_gcnt;

endmodule
`default_nettype wire

// File: tb/tb_icg_enable_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_icg_enable_ctrl
//  Purpose  : Directed, table-driven checks of icg_enable_ctrl (two configs).
//  Revision : 1.0 - initial release
// ============================================================================
module tb_icg_enable_ctrl;

    logic clk = 1'b0;
    logic rn, busy, force_on, se, clr;

    logic       a_e, a_te, a_ready, a_gated;
    logic [3:0] a_gcnt;
    logic       b_e, b_te, b_ready, b_gated;
    logic [15:0] b_gcnt;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    // Main configuration: short hysteresis, 2-cycle wake, 4-bit statistic.
    icg_enable_ctrl #(.IDLE_CYCLES(4), .WAKE_LAT(2), .CNT_W(4)) dut_a (
        .CLK(clk), .RN(rn), .BUSY(busy), .FORCE_ON(force_on), .SE(se), .CLR(clr),
        .E(a_e), .TE(a_te), .READY(a_ready), .GATED(a_gated), .GCNT(a_gcnt)
    );

    // Zero wake-latency configuration.
    icg_enable_ctrl #(.IDLE_CYCLES(4), .WAKE_LAT(0), .CNT_W(16)) dut_b (
        .CLK(clk), .RN(rn), .BUSY(busy), .FORCE_ON(force_on), .SE(se), .CLR(clr),
        .E(b_e), .TE(b_te), .READY(b_ready), .GATED(b_gated), .GCNT(b_gcnt)
    );

    typedef struct {
        logic       rn, busy, force_on, se, clr;
        logic       e, ready, gated;
        logic [3:0] gcnt;
    } vec_t;

    vec_t vecs[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic add(input logic r, input logic b, input logic f, input logic s, input logic c,
                       input logic e, input logic rd, input logic g, input logic [3:0] n);
        vec_t v;
        v.rn = r; v.busy = b; v.force_on = f; v.se = s; v.clr = c;
        v.e = e; v.ready = rd; v.gated = g; v.gcnt = n;
        vecs.push_back(v);
    endtask

    task automatic set_in(input logic r, input logic b, input logic f, input logic s, input logic c);
        @(negedge clk);
        rn = r; busy = b; force_on = f; se = s; clr = c;
        #1;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_a(input string tag, input logic e, input logic rd, input logic g, input logic [3:0] n);
        check({tag, ".E"},     {31'd0, a_e},     {31'd0, e});
        check({tag, ".READY"}, {31'd0, a_ready}, {31'd0, rd});
        check({tag, ".GATED"}, {31'd0, a_gated}, {31'd0, g});
        check({tag, ".GCNT"},  {28'd0, a_gcnt},  {28'd0, n});
    endtask

    initial begin
        rn = 1'b0; busy = 1'b0; force_on = 1'b0; se = 1'b0; clr = 1'b0;

        //  rn b  f  se clr   E  RDY GAT GCNT
        for (int i = 1; i <= 5; i++) add(1, 0, 0, 0, 0, 0, 0, 1, 4'(i));   // idle in GATED
        add(1, 1, 0, 0, 0,  1, 0, 0, 4'd6);   // wake starts
        add(1, 1, 0, 0, 0,  1, 0, 0, 4'd6);
        add(1, 1, 0, 0, 0,  1, 1, 0, 4'd6);   // READY after WAKE_LAT more edges
        add(1, 0, 0, 0, 0,  1, 1, 0, 4'd6);   // 3 idle cycles: hysteresis holds
        add(1, 0, 0, 0, 0,  1, 1, 0, 4'd6);
        add(1, 0, 0, 0, 0,  1, 1, 0, 4'd6);
        add(1, 1, 0, 0, 0,  1, 1, 0, 4'd6);   // back to RUN, no wake latency
        add(1, 0, 0, 0, 0,  1, 1, 0, 4'd6);   // long idle: DRAIN cnt 3
        add(1, 0, 0, 0, 0,  1, 1, 0, 4'd6);
        add(1, 0, 0, 0, 0,  1, 1, 0, 4'd6);
        add(1, 0, 0, 0, 0,  1, 1, 0, 4'd6);   // DRAIN cnt 0
        add(1, 0, 0, 0, 0,  0, 0, 1, 4'd6);   // gated
        add(1, 0, 0, 0, 0,  0, 0, 1, 4'd7);
        add(1, 0, 1, 0, 0,  1, 0, 0, 4'd8);   // FORCE_ON wakes
        add(1, 0, 1, 0, 0,  1, 0, 0, 4'd8);
        for (int i = 0; i < 4; i++) add(1, 0, 1, 0, 0, 1, 1, 0, 4'd8);  // held on
        add(1, 0, 0, 1, 0,  1, 1, 0, 4'd8);   // scan enable, FSM keeps draining
        add(1, 0, 0, 1, 0,  1, 1, 0, 4'd8);
        add(1, 0, 0, 1, 0,  1, 1, 0, 4'd8);
        add(1, 0, 0, 1, 0,  1, 1, 0, 4'd8);
        add(1, 0, 0, 1, 0,  0, 0, 1, 4'd8);
        for (int i = 9; i <= 15; i++) add(1, 0, 0, 0, 0, 0, 0, 1, 4'(i));
        add(1, 0, 0, 0, 0,  0, 0, 1, 4'd15);  // saturated
        add(1, 0, 0, 0, 0,  0, 0, 1, 4'd15);
        add(1, 0, 0, 0, 1,  0, 0, 1, 4'd0);   // CLR wins over increment
        add(1, 0, 0, 0, 0,  0, 0, 1, 4'd1);
        add(1, 0, 0, 0, 0,  0, 0, 1, 4'd2);

        // Reset state
        #12;
        check_a("reset", 1'b0, 1'b0, 1'b1, 4'd0);
        check("reset.TE", {31'd0, a_te}, 32'd0);

        foreach (vecs[i]) begin
            set_in(vecs[i].rn, vecs[i].busy, vecs[i].force_on, vecs[i].se, vecs[i].clr);
            check($sformatf("vec%0d.TE", i), {31'd0, a_te}, {31'd0, vecs[i].se});
            tick();
            check_a($sformatf("vec%0d", i), vecs[i].e, vecs[i].ready, vecs[i].gated, vecs[i].gcnt);
        end

        // Reset asserted mid-WAKE (cnt=1) aborts without waiting for a clock edge
        set_in(1, 1, 0, 0, 0);
        tick();
        check_a("midwake.enter", 1'b1, 1'b0, 1'b0, 4'd3);
        @(negedge clk);
        rn = 1'b0;
        #1;
        check_a("midwake.async", 1'b0, 1'b0, 1'b1, 4'd0);
        set_in(1, 1, 0, 0, 0);
        tick();
        check_a("rewake.1", 1'b1, 1'b0, 1'b0, 4'd1);
        tick();
        check_a("rewake.2", 1'b1, 1'b0, 1'b0, 4'd1);
        tick();
        check_a("rewake.3", 1'b1, 1'b1, 1'b0, 4'd1);

        // Zero wake latency: E and READY rise together
        set_in(0, 0, 0, 0, 0);
        check("b.reset.GATED", {31'd0, b_gated}, 32'd1);
        set_in(1, 0, 0, 0, 0);
        tick();
        check("b.idle.E", {31'd0, b_e}, 32'd0);
        check("b.idle.GCNT", {16'd0, b_gcnt}, 32'd1);
        set_in(1, 1, 0, 0, 0);
        tick();
        check("b.wake.E", {31'd0, b_e}, 32'd1);
        check("b.wake.READY", {31'd0, b_ready}, 32'd1);
        check("b.wake.GATED", {31'd0, b_gated}, 32'd0);
        set_in(1, 0, 0, 0, 0);
        for (int i = 0; i < 4; i++) tick();
        check("b.drain.E", {31'd0, b_e}, 32'd1);
        tick();
        check("b.gate.E", {31'd0, b_e}, 32'd0);
        check("b.gate.READY", {31'd0, b_ready}, 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
